// File: rtl/boxhead_soc_irq_ctrl_if.sv
// Register bus between the CPU side and the interrupt controller.
// Ports: address, chipselect, write_n, writedata (master->slave), readdata (slave->master).
interface boxhead_soc_irq_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/boxhead_soc_irq_ctrl.sv
// Edge-latched interrupt controller with pending/mask/active/vector registers.
// Ports: clk, reset (sync, active-high), bus (slave regs), irq_in[NUM_SRC], irq.
// Optional per-source missed-edge counters at addresses 6/7 when
// BOXHEAD_IRQ_CTRL_OVF_COUNT_EN is defined.
module boxhead_soc_irq_ctrl #(
    parameter int          NUM_SRC    = 8,
    parameter logic [15:0] RESET_MASK = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    boxhead_soc_irq_ctrl_if.slave bus,
    input  logic [NUM_SRC-1:0]    irq_in,
    output logic                  irq
);

    localparam logic [4:0] NSRC = 5'(NUM_SRC);

    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] set;
    logic [15:0]        ack_onehot;
    logic [15:0]        rd_mux;
    logic [3:0]         low_idx;
    logic               wr;

    always_comb begin
        wr     = bus.chipselect & ~bus.write_n;
        edges  = irq_in & ~prev;
        active = pending & mask;
        ack_onehot = 16'h0001 << bus.writedata[3:0];

        clr = '0;
        set = '0;
        if (wr) begin
            case (bus.address)
                3'd0: clr = bus.writedata[NUM_SRC-1:0];
                3'd4: begin
                    // out-of-range ACK indices are silently dropped
                    if ({1'b0, bus.writedata[3:0]} < NSRC)
                        clr = ack_onehot[NUM_SRC-1:0];
                end
                3'd5: set = bus.writedata[NUM_SRC-1:0];
                default: ;
            endcase
        end
    end

    // scan downward so the lowest active index is the one that sticks
    always_comb begin
        low_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i])
                low_idx = 4'(i);
        end
    end

`ifdef BOXHEAD_IRQ_CTRL_OVF_COUNT_EN
    logic [7:0] ovf_cnt [NUM_SRC];
    logic [3:0] ovf_sel;
    logic [7:0] sel_cnt;

    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ovf_sel == 4'(i))
                sel_cnt = ovf_cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sel <= '0;
            for (int i = 0; i < NUM_SRC; i++)
                ovf_cnt[i] <= '0;
        end else begin
            if (wr && bus.address == 3'd6)
                ovf_sel <= bus.writedata[3:0];
            for (int i = 0; i < NUM_SRC; i++) begin
                // a software clear beats a same-cycle missed edge
                if (wr && bus.address == 3'd7 && ovf_sel == 4'(i))
                    ovf_cnt[i] <= '0;
                else if (edges[i] && pending[i] && ovf_cnt[i] != 8'hFF)
                    ovf_cnt[i] <= ovf_cnt[i] + 8'd1;
            end
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            3'd0: rd_mux = 16'(pending);
            3'd1: rd_mux = 16'(mask);
            3'd2: rd_mux = 16'(active);
            3'd3: rd_mux = (|active) ? {1'b1, 11'd0, low_idx} : 16'h0000;
`ifdef BOXHEAD_IRQ_CTRL_OVF_COUNT_EN
            3'd6: rd_mux = 16'(ovf_sel);
            3'd7: rd_mux = 16'(sel_cnt);
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev         <= '0;
            pending      <= '0;
            mask         <= RESET_MASK[NUM_SRC-1:0];
            bus.readdata <= '0;
            irq          <= 1'b0;
        end else begin
            prev <= irq_in;
            // sets are OR'd in after the clear so they win on collision
            pending <= (pending & ~clr) | edges | set;
            if (wr && bus.address == 3'd1)
                mask <= bus.writedata[NUM_SRC-1:0];
            bus.readdata <= rd_mux;
            irq          <= |active;
        end
    end

endmodule

// File: tb/tb_boxhead_soc_irq_ctrl.sv
// Randomized and directed bench for boxhead_soc_irq_ctrl against a
// behavioural register model.
module tb_boxhead_soc_irq_ctrl;

    localparam int          N    = 8;
    localparam logic [15:0] RM   = 16'h0001;
    localparam logic [15:0] FULL = 16'h00FF;

    logic       clk;
    logic       reset;
    logic [7:0] irq_in;
    logic       irq;

    boxhead_soc_irq_ctrl_if bus ();

    boxhead_soc_irq_ctrl #(
        .NUM_SRC    (N),
        .RESET_MASK (RM)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus.slave),
        .irq_in (irq_in),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pend;
    logic [15:0] m_mask;
    logic [15:0] m_prev;
    logic [15:0] m_rd;
    logic        m_irq;
    logic [3:0]  m_sel;
    int          m_cnt [16];

    function automatic logic [15:0] model_read(input logic [2:0] a);
        logic [15:0] act;
        logic [15:0] r;
        act = m_pend & m_mask;
        r = 16'h0000;
        case (a)
            3'd0: r = m_pend;
            3'd1: r = m_mask;
            3'd2: r = act;
            3'd3: begin
                for (int i = N - 1; i >= 0; i--)
                    if (act[i]) r = 16'h8000 | 16'(i);
            end
`ifdef BOXHEAD_IRQ_CTRL_OVF_COUNT_EN
            3'd6: r = 16'(m_sel);
            3'd7: r = (int'(m_sel) < N) ? 16'(m_cnt[m_sel]) : 16'h0000;
`endif
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    task automatic model_step();
        logic [15:0] e, clr, set, nrd, iv;
        logic        w, ni, cclr;
        iv   = {8'h00, irq_in};
        e    = iv & ~m_prev & FULL;
        w    = bus.chipselect && !bus.write_n;
        nrd  = model_read(bus.address);
        ni   = (m_pend & m_mask) != 16'h0000;
        clr  = 16'h0000;
        set  = 16'h0000;
        cclr = 1'b0;
        if (reset) begin
            m_pend = 16'h0000;
            m_prev = 16'h0000;
            m_mask = RM & FULL;
            m_sel  = 4'd0;
            for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            m_rd  = 16'h0000;
            m_irq = 1'b0;
        end else begin
            if (w) begin
                case (bus.address)
                    3'd0: clr = bus.writedata & FULL;
                    3'd4: if (int'(bus.writedata[3:0]) < N)
                              clr = 16'h0001 << bus.writedata[3:0];
                    3'd5: set = bus.writedata & FULL;
                    default: ;
                endcase
            end
`ifdef BOXHEAD_IRQ_CTRL_OVF_COUNT_EN
            cclr = w && bus.address == 3'd7;
            for (int i = 0; i < N; i++) begin
                if (cclr && int'(m_sel) == i) m_cnt[i] = 0;
                else if (e[i] && m_pend[i] && m_cnt[i] < 255) m_cnt[i]++;
            end
            if (w && bus.address == 3'd6) m_sel = bus.writedata[3:0];
`endif
            if (w && bus.address == 3'd1) m_mask = bus.writedata & FULL;
            m_pend = (m_pend & ~clr) | e | set;
            m_prev = iv;
            m_rd   = nrd;
            m_irq  = ni;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [15:0] v);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        tick();
        v = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        irq_in = 8'h01;
        do_reset();
        checks++;
        if (irq !== 1'b0 || bus.readdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_out: irq=%b rd=%h want 0/0000", irq, bus.readdata);
        end
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq1: got %b want 0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1 || irq !== m_irq) begin
            errors++;
            $display("FAIL reset_irq2: got %b want 1", irq);
        end
        read_reg(3'd0, v);
        checks++;
        if (v !== 16'h0001) begin
            errors++;
            $display("FAIL reset_pend: got %h want 0001", v);
        end
        irq_in = 8'h00;
        bus.address    = 3'd1;
        bus.writedata  = 16'h00F0;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        reset = 1'b1;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        reset = 1'b0;
        read_reg(3'd1, v);
        checks++;
        if (v !== 16'h0001 || v !== m_rd) begin
            errors++;
            $display("FAIL reset_mask: got %h want 0001", v);
        end
    endtask

    task automatic test_edge();
        logic [15:0] v;
        do_reset();
        write_reg(3'd1, 16'h0001);
        irq_in = 8'h01;
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL edge_irq_early: got %b want 0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL edge_irq: got %b want 1", irq);
        end
        repeat (18) tick();
        read_reg(3'd0, v);
        checks++;
        if (v !== 16'h0001) begin
            errors++;
            $display("FAIL edge_pend: got %h want 0001", v);
        end
        write_reg(3'd0, 16'h0001);
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL edge_clr_irq: got %b want 0", irq);
        end
        read_reg(3'd0, v);
        checks++;
        if (v !== 16'h0000 || v !== m_rd) begin
            errors++;
            $display("FAIL edge_retrig: got %h want 0000", v);
        end
        irq_in = 8'h00;
    endtask

    task automatic test_vector();
        logic [15:0] v;
        do_reset();
        write_reg(3'd1, 16'h00FF);
        irq_in = 8'h24;
        tick();
        irq_in = 8'h00;
        read_reg(3'd3, v);
        checks++;
        if (v !== 16'h8002) begin
            errors++;
            $display("FAIL vec_first: got %h want 8002", v);
        end
        write_reg(3'd4, 16'h0002);
        read_reg(3'd3, v);
        checks++;
        if (v !== 16'h8005) begin
            errors++;
            $display("FAIL vec_second: got %h want 8005", v);
        end
        write_reg(3'd4, 16'h0005);
        read_reg(3'd3, v);
        checks++;
        if (v !== 16'h0000 || irq !== 1'b0) begin
            errors++;
            $display("FAIL vec_empty: got %h irq=%b want 0000 irq=0", v, irq);
        end
    endtask

    task automatic test_collision();
        logic [15:0] v;
        do_reset();
        irq_in = 8'h08;
        tick();
        irq_in = 8'h00;
        tick();
        irq_in = 8'h08;
        write_reg(3'd0, 16'h0008);
        irq_in = 8'h00;
        read_reg(3'd0, v);
        checks++;
        if (v !== 16'h0008 || v !== m_rd) begin
            errors++;
            $display("FAIL collide_pend: got %h want 0008", v);
        end
    endtask

    task automatic test_force();
        logic [15:0] v;
        do_reset();
        write_reg(3'd1, 16'h0000);
        write_reg(3'd5, 16'h0010);
        read_reg(3'd0, v);
        checks++;
        if (v !== 16'h0010 || irq !== 1'b0) begin
            errors++;
            $display("FAIL force_pend: got %h irq=%b want 0010 irq=0", v, irq);
        end
        write_reg(3'd1, 16'h0010);
        tick();
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL force_irq: got %b want 1", irq);
        end
        write_reg(3'd4, 16'h0009);
        read_reg(3'd0, v);
        checks++;
        if (v !== 16'h0010) begin
            errors++;
            $display("FAIL ack_oob: got %h want 0010", v);
        end
        read_reg(3'd2, v);
        checks++;
        if (v !== 16'h0010) begin
            errors++;
            $display("FAIL active: got %h want 0010", v);
        end
        read_reg(3'd5, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL force_read: got %h want 0000", v);
        end
        write_reg(3'd1, 16'h0000);
        tick();
        read_reg(3'd0, v);
        checks++;
        if (irq !== 1'b0 || v !== 16'h0010) begin
            errors++;
            $display("FAIL mask_off: irq=%b pend=%h want 0/0010", irq, v);
        end
    endtask

    task automatic test_ovf();
        logic [15:0] v;
        do_reset();
`ifdef BOXHEAD_IRQ_CTRL_OVF_COUNT_EN
        write_reg(3'd6, 16'h0001);
        for (int i = 0; i < 300; i++) begin
            irq_in = 8'h02;
            tick();
            irq_in = 8'h00;
            tick();
        end
        read_reg(3'd7, v);
        checks++;
        if (v !== 16'd255 || v !== m_rd) begin
            errors++;
            $display("FAIL ovf_sat: got %h want 00ff", v);
        end
        write_reg(3'd7, 16'h0000);
        read_reg(3'd7, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL ovf_clr: got %h want 0000", v);
        end
`else
        write_reg(3'd6, 16'h0001);
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        tick();
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        read_reg(3'd7, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL ovf_absent7: got %h want 0000", v);
        end
        read_reg(3'd6, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL ovf_absent6: got %h want 0000", v);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            irq_in         = 8'($urandom);
            bus.address    = 3'($urandom_range(0, 7));
            bus.writedata  = 16'($urandom);
            bus.chipselect = 1'($urandom);
            bus.write_n    = ($urandom_range(0, 3) != 0);
            reset          = ($urandom_range(0, 63) == 0);
            tick();
            checks++;
            if (bus.readdata !== m_rd || irq !== m_irq) begin
                errors++;
                $display("FAIL rand_%0d: rd=%h irq=%b want rd=%h irq=%b",
                         i, bus.readdata, irq, m_rd, m_irq);
            end
        end
        reset          = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        irq_in         = 8'h00;
    endtask

    initial begin
        m_pend = '0;
        m_mask = '0;
        m_prev = '0;
        m_rd   = '0;
        m_irq  = 1'b0;
        m_sel  = '0;
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        reset          = 1'b1;
        irq_in         = 8'h00;
        bus.address    = 3'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 16'h0000;
        #1;
        test_reset();
        test_edge();
        test_vector();
        test_collision();
        test_force();
        test_ovf();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boxhead_soc_irq_ctrl.md
BOXHEAD_SOC_IRQ_CTRL -- requirements
Module: boxhead_soc_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of interrupt sources (legal 1..16).
REQ-002 SHALL have parameter RESET_MASK, default 16'h0000, mask register value after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port address  input  3  register select.
REQ-006 SHALL have port chipselect  input  1  slave select.
REQ-007 SHALL have port write_n  input  1  active-low write strobe.
REQ-008 SHALL have port writedata  input  16  write data.
REQ-009 SHALL have port readdata  output  16  registered read data.
REQ-010 SHALL have port irq_in  input  NUM_SRC  level interrupt requests (e.g. timer irq); bit 0 highest priority.
REQ-011 SHALL have port irq  output  1  aggregated interrupt to the CPU.

Function
REQ-012 SHALL register irq_in once (prev) and detect rising edges as irq_in & ~prev; a held-high level raises exactly one edge.
REQ-013 SHALL set pending[n] on an edge on source n; pending holds until cleared by software.
REQ-014 SHALL define write strobe wr = chipselect & ~write_n; a write with chipselect low has no effect.
REQ-015 SHALL decode address 0 PENDING: read pending; write-1-to-clear per bit.
REQ-016 SHALL decode address 1 MASK: read/write; bit n set enables source n.
REQ-017 SHALL decode address 2 ACTIVE: read-only, pending & mask; writes ignored.
REQ-018 SHALL decode address 3 VECTOR: read-only; bit15 = any active, bits3:0 = lowest active index, otherwise 0.
REQ-019 SHALL decode address 4 ACK: write clears pending[writedata[3:0]]; an index >= NUM_SRC is ignored; reads 0.
REQ-020 SHALL decode address 5 FORCE: write sets pending bits where writedata is 1 (software trigger); reads 0.
REQ-021 SHALL, when a hardware edge or FORCE set coincides with a clear of the same bit, give the set priority; the pending bit ends at 1.
REQ-022 SHALL register readdata from the address mux every cycle, so read data is valid one cycle after address; bits >= NUM_SRC read 0.
REQ-023 SHALL drive irq as a register of |(pending & mask): one-cycle latency from edge or mask change.
REQ-024 SHALL change irq only through pending or mask; mask off with pending set drops irq next cycle, and pending is retained.

Reset
REQ-025 SHALL on reset clear pending, prev, readdata and irq, and load mask with RESET_MASK[NUM_SRC-1:0].
REQ-026 SHALL treat an input already high at reset release as an edge on the first cycle after release, because prev resets to 0.
REQ-027 SHALL let reset asserted mid-transaction override any concurrent write.

Configuration
REQ-028 SHALL provide a missed-interrupt counter feature compiled in only when macro BOXHEAD_IRQ_CTRL_OVF_COUNT_EN is defined.
REQ-029 SHALL, with BOXHEAD_IRQ_CTRL_OVF_COUNT_EN defined:
- maintain per source an 8-bit counter that increments, saturating at 255, on an edge arriving while pending[n] is already 1;
- use address 6 OVF_SEL (read/write 4-bit index);
- use address 7 OVF_CNT: read returns the selected counter zero-extended; write clears the selected counter;
- clear all counters on reset;
- let a clear win over a simultaneous increment.
REQ-030 SHALL, without BOXHEAD_IRQ_CTRL_OVF_COUNT_EN defined, omit the counters; addresses 6 and 7 read 0 and ignore writes.

Verification
REQ-031 SHALL cover: mask=0x0001, irq_in[0] rises and stays high 20 cycles -> pending=0x0001 once; irq=1 two cycles after the rise; write PENDING 0x0001 -> irq=0 next cycle, no re-trigger.
REQ-032 SHALL cover: mask=0x00FF, edges on sources 5 and 2 in the same cycle -> VECTOR reads 0x8002; ACK 2 -> VECTOR 0x8005; ACK 5 -> VECTOR 0x0000 and irq=0.
REQ-033 SHALL cover: pending[3]=1, write PENDING 0x0008 in the same cycle as a new edge on source 3 -> pending[3] remains 1.
REQ-034 SHALL cover: mask=0, FORCE 0x0010 -> PENDING reads 0x0010, irq=0; then MASK 0x0010 -> irq=1 one cycle later; ACK 9 with NUM_SRC=8 -> no change.
REQ-035 SHALL cover: with BOXHEAD_IRQ_CTRL_OVF_COUNT_EN, 300 edges on source 1 without clearing -> OVF_SEL=1, OVF_CNT reads 255; write OVF_CNT -> reads 0; without the macro, address 7 reads 0.
REQ-036 SHALL cover: irq_in=0x01 held through reset, RESET_MASK=0x0001 -> pending[0]=1 and irq=1 two cycles after reset deasserts; reset mid-write of MASK -> mask=RESET_MASK.
